// File: rtl/fdiv_monitor_if.sv
// rtl/fdiv_monitor_if.sv - strobe/measurement bundle between a divider checker and its user
interface fdiv_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             strb;
    logic [CNT_W-1:0] exp_div;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             lock;
    logic             err;
    logic             ovf;

    modport master (
        output en, strb, exp_div,
        input  period, period_vld, lock, err, ovf
    );

    modport slave (
        input  en, strb, exp_div,
        output period, period_vld, lock, err, ovf
    );
endinterface

// File: rtl/fdiv_monitor.sv
// rtl/fdiv_monitor.sv - measures divided-strobe periods and reports lock/err/ovf
module fdiv_monitor #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic          clk,
    input  logic          rst,
    fdiv_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] period_d;
    logic [3:0]       match_cnt, match_d, match_inc;
    logic             strb_q, strb_edge;
    logic             vld_d, lock_d, err_d, ovf_d;

    assign strb_edge = bus.strb & ~strb_q;
    assign match_inc = (match_cnt >= LOCK_TGT) ? LOCK_TGT : match_cnt + 4'd1;

    // Next-state and next-output decode; pulses default low, levels hold
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        match_d  = match_cnt;
        period_d = bus.period;
        lock_d   = bus.lock;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        ovf_d    = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            match_d = '0;
            lock_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d   = '0;
                    match_d = '0;
                    lock_d  = 1'b0;
                    state_d = ARM;
                end
                ARM: begin
                    if (strb_edge) begin
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (strb_edge) begin
                        period_d = cnt;
                        vld_d    = 1'b1;
                        cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt == bus.exp_div) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_TGT) begin
                                lock_d = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            match_d = '0;
                            lock_d  = 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        // Gap too long to measure: drop back and wait for a fresh edge
                        ovf_d   = 1'b1;
                        match_d = '0;
                        lock_d  = 1'b0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; the strobe history updates every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            match_cnt      <= '0;
            strb_q         <= 1'b0;
            bus.period     <= '0;
            bus.period_vld <= 1'b0;
            bus.lock       <= 1'b0;
            bus.err        <= 1'b0;
            bus.ovf        <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            match_cnt      <= match_d;
            strb_q         <= bus.strb;
            bus.period     <= period_d;
            bus.period_vld <= vld_d;
            bus.lock       <= lock_d;
            bus.err        <= err_d;
            bus.ovf        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fdiv_monitor.sv
// tb/tb_fdiv_monitor.sv - directed and random checks of fdiv_monitor against an edge-timing model
module tb_fdiv_monitor;
    localparam int CNT_W  = 4;
    localparam int LOCK_N = 3;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    fdiv_monitor_if #(.CNT_W(CNT_W)) bus ();

    fdiv_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    bit cur_en  = 1'b0;
    int cur_exp = 5;

    // Reference model: edge timestamps rather than a running counter
    bit m_prev    = 1'b0;
    bit m_idle    = 1'b1;
    bit m_has_ref = 1'b0;
    int m_tref    = 0;
    int m_match   = 0;
    bit m_lock    = 1'b0;
    int m_period  = 0;
    bit m_vld     = 1'b0;
    bit m_err     = 1'b0;
    bit m_ovf     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    endtask

    task automatic step(input bit r, input bit s);
        bit e;
        int el;
        rst         = r;
        bus.strb    = s;
        bus.en      = cur_en;
        bus.exp_div = CNT_W'(cur_exp);
        e     = s && !m_prev;
        m_vld = 1'b0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        if (r) begin
            m_prev    = 1'b0;
            m_idle    = 1'b1;
            m_has_ref = 1'b0;
            m_match   = 0;
            m_lock    = 1'b0;
            m_period  = 0;
        end else begin
            m_prev = s;
            if (!cur_en) begin
                m_idle    = 1'b1;
                m_has_ref = 1'b0;
                m_match   = 0;
                m_lock    = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_has_ref) begin
                el = cyc - m_tref;
                if (e) begin
                    m_period = el;
                    m_vld    = 1'b1;
                    m_tref   = cyc;
                    if (el == cur_exp) begin
                        m_match = (m_match < LOCK_N) ? m_match + 1 : LOCK_N;
                        if (m_match == LOCK_N) m_lock = 1'b1;
                    end else begin
                        m_err   = 1'b1;
                        m_match = 0;
                        m_lock  = 1'b0;
                    end
                end else if (el == MAXC) begin
                    m_ovf     = 1'b1;
                    m_has_ref = 1'b0;
                    m_match   = 0;
                    m_lock    = 1'b0;
                end
            end else if (e) begin
                m_has_ref = 1'b1;
                m_tref    = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("period",     32'(bus.period),     32'(m_period));
        check("period_vld", 32'(bus.period_vld), 32'(m_vld));
        check("lock",       32'(bus.lock),       32'(m_lock));
        check("err",        32'(bus.err),        32'(m_err));
        check("ovf",        32'(bus.ovf),        32'(m_ovf));
    endtask

    task automatic train(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < per; j++) step(1'b0, j < hi);
        end
    endtask

    task automatic idle_gap(input int n, input int new_exp);
        cur_en  = 1'b0;
        cur_exp = new_exp;
        for (int j = 0; j < n; j++) step(1'b0, 1'b0);
        cur_en = 1'b1;
    endtask

    int act;
    int per;

    initial begin
        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("reset_period", 32'(bus.period), 32'd0);
        check("reset_lock",   32'(bus.lock),   32'd0);

        // Divide-by-5, single-cycle strobe: lock on the 4th edge
        cur_en = 1'b1;
        step(1'b0, 1'b0);
        train(5, 1, 6);
        check("lock_after_train5", 32'(bus.lock), 32'd1);

        // One short interval then recovery
        train(4, 1, 1);
        train(5, 1, 4);

        // Strobe stops: overflow, then two edges give one measurement
        for (int j = 0; j < 20; j++) step(1'b0, 1'b0);
        train(5, 1, 3);

        // Wide strobe, divide-by-8
        idle_gap(2, 8);
        train(8, 3, 6);

        // Reset mid-period while locked
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("rst_lock", 32'(bus.lock), 32'd0);
        train(8, 3, 6);

        // Enable dropped while locked: period holds, no pulses
        idle_gap(6, 8);
        check("en_period_hold", 32'(bus.period), 32'd8);
        train(8, 2, 5);

        // exp_div of 0 and 1 never match
        idle_gap(2, 1);
        train(3, 1, 5);
        idle_gap(2, 0);
        train(2, 1, 5);

        // Strobe stuck high ends in overflow
        idle_gap(2, 5);
        train(5, 1, 3);
        for (int j = 0; j < 20; j++) step(1'b0, 1'b1);
        train(5, 1, 4);

        // Measurement at the counter boundary: 15 measures, 16 overflows
        idle_gap(2, 15);
        train(15, 1, 5);
        train(16, 1, 3);

        // Random strobe trains, enable gaps and resets
        idle_gap(2, 5);
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 19);
            if (act == 0) begin
                step(1'b1, 1'b0);
            end else if (act < 3) begin
                idle_gap($urandom_range(1, 3), $urandom_range(0, 12));
            end else begin
                if ($urandom_range(0, 3) == 0) per = $urandom_range(2, 18);
                else per = cur_exp;
                if (per < 2) per = 2;
                train(per, $urandom_range(1, per - 1), $urandom_range(1, 6));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
